// File: rtl/bss_pkg.sv
// Shared types and constants for the bit-serial subtract sequencer.
package bss_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } bss_state_e;

    localparam int unsigned BSS_WIDTH_DEF = 8;

endpackage

// File: rtl/bit_serial_sub_ctrl_fs_cell.sv
// Combinational 1-bit full-subtractor cell: d = x - y - bin, bout = borrow out.
module fs_cell (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/bit_serial_sub_ctrl.sv
// LSB-first N-bit subtractor built around a single fs_cell, one bit per clock.
// Define BSS_FLAGS_EN to add the registered zero and signed-overflow flags.
module bit_serial_sub_ctrl
    import bss_pkg::*;
#(
    parameter int unsigned WIDTH = BSS_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
`ifdef BSS_FLAGS_EN
    ,
    output logic             zero,
    output logic             ovf
`endif
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    bss_state_e       state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] d_sr;
    logic [WIDTH-1:0] d_sr_next;
    logic [CNT_W-1:0] cnt;
    logic             bflop;
    logic             cell_d, cell_bout;
    logic             last_bit;

`ifdef BSS_FLAGS_EN
    logic a_msb, b_msb;
`endif

    fs_cell u_cell (
        .x    (a_sr[0]),
        .y    (b_sr[0]),
        .bin  (bflop),
        .d    (cell_d),
        .bout (cell_bout)
    );

    assign last_bit = (cnt == CNT_W'(WIDTH - 1));
    // Only WIDTH-1 bits are stored; the live cell output completes the word on the final bit.
    assign d_sr_next = {cell_d, d_sr};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = S_RUN;
                end
            end
            S_RUN: begin
                busy = 1'b1;
                if (last_bit) begin
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            d_sr   <= '0;
            cnt    <= '0;
            bflop  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
`ifdef BSS_FLAGS_EN
            a_msb  <= 1'b0;
            b_msb  <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        d_sr  <= '0;
                        cnt   <= '0;
                        bflop <= 1'b0;
`ifdef BSS_FLAGS_EN
                        a_msb <= a[WIDTH-1];
                        b_msb <= b[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
                    b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
                    d_sr  <= d_sr_next[WIDTH-1:1];
                    bflop <= cell_bout;
                    if (last_bit) begin
                        diff   <= d_sr_next;
                        borrow <= cell_bout;
`ifdef BSS_FLAGS_EN
                        zero   <= (d_sr_next == '0);
                        ovf    <= (a_msb != b_msb) && (cell_d != a_msb);
`endif
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bit_serial_sub_ctrl.sv
// Scoreboard bench for bit_serial_sub_ctrl at WIDTH=8; flag checks follow BSS_FLAGS_EN.
module tb_bit_serial_sub_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef BSS_FLAGS_EN
    logic         zero, ovf;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] diff;
        logic         borrow;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];

    bit_serial_sub_ctrl #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
`ifdef BSS_FLAGS_EN
        ,
        .zero   (zero),
        .ovf    (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        exp_t       e;
        logic [W:0] full;
        full     = {1'b0, ma} - {1'b0, mb};
        e.diff   = full[W-1:0];
        e.borrow = full[W];
        e.zero   = (full[W-1:0] == '0);
        e.ovf    = (ma[W-1] != mb[W-1]) && (full[W-1] != ma[W-1]);
        return e;
    endfunction

    task automatic check_outputs_zero(input string tag);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     tag, busy, done, diff, borrow);
        end
`ifdef BSS_FLAGS_EN
        checks++;
        if (zero !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL %s_flags: zero=%b ovf=%b, required 0 0", tag, zero, ovf);
        end
`endif
    endtask

    // Entered one cycle per tick after the start edge; lat0 counts ticks already spent in RUN.
    task automatic wait_done(input int lat0, input string tag);
        int           lat;
        logic [W-1:0] hold_d;
        logic         hold_b;
        exp_t         e;
        lat    = lat0;
        hold_d = diff;
        hold_b = borrow;
        while (done !== 1'b1 && lat < W + 4) begin
            checks++;
            if (busy !== 1'b1 || diff !== hold_d || borrow !== hold_b) begin
                errors++;
                $display("FAIL %s_run: busy=%b diff=%h borrow=%b, required 1 %h %b",
                         tag, busy, diff, borrow, hold_d, hold_b);
            end
            tick();
            lat++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, lat);
            return;
        end
        checks++;
        if (lat != W || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_latency: done at %0d busy=%b, required %0d busy=1", tag, lat, busy, W);
        end
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: unexpected done with empty scoreboard, required none", tag);
        end else begin
            e = sb.pop_front();
            if (diff !== e.diff || borrow !== e.borrow) begin
                errors++;
                $display("FAIL %s_result: diff=%h borrow=%b, required %h %b",
                         tag, diff, borrow, e.diff, e.borrow);
            end
`ifdef BSS_FLAGS_EN
            checks++;
            if (zero !== e.zero || ovf !== e.ovf) begin
                errors++;
                $display("FAIL %s_flags: zero=%b ovf=%b, required %b %b", tag, zero, ovf, e.zero, e.ovf);
            end
`endif
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || diff !== e.diff || borrow !== e.borrow) begin
            errors++;
            $display("FAIL %s_after: done=%b busy=%b diff=%h borrow=%b, required 0 0 %h %b",
                     tag, done, busy, diff, borrow, e.diff, e.borrow);
        end
    endtask

    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb2, input string tag);
        sb.push_back(model(ta, tb2));
        start = 1'b1;
        a     = ta;
        b     = tb2;
        tick();
        start = 1'b0;
        a     = W'($urandom);
        b     = W'($urandom);
        wait_done(0, tag);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_outputs_zero("idle_after_reset");
    endtask

    task automatic test_vectors();
        run_op(8'h05, 8'h03, "v_05_03");
        run_op(8'h03, 8'h05, "v_03_05");
        run_op(8'h5A, 8'h5A, "v_5a_5a");
        run_op(8'h80, 8'h01, "v_80_01");
        run_op(8'h00, 8'hFF, "v_00_ff");
        run_op(8'h7F, 8'hFF, "v_7f_ff");
    endtask

    task automatic test_ignore_start();
        sb.push_back(model(8'h37, 8'h21));
        start = 1'b1;
        a     = 8'h37;
        b     = 8'h21;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        a     = 8'h10;
        b     = 8'hC3;
        tick();
        start = 1'b0;
        wait_done(3, "ignore_start");
        for (int i = 0; i < W + 3; i++) begin
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL ignore_start_extra: done=%b busy=%b at idle cycle %0d, required 0 0",
                         done, busy, i);
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        a     = 8'hC4;
        b     = 8'h19;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < W + 3; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL async_reset_nodone: done=%b busy=%b at cycle %0d, required 0 0",
                         done, busy, i);
            end
        end
        run_op(8'hFF, 8'h0F, "after_reset");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            run_op(W'($urandom), W'($urandom), "b2b_random");
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_ignore_start();
        test_async_reset();
        test_back_to_back();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
